// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between two agents and the mux2 arbiter.
// master = requesting agents side, slave = arbiter side.
interface mux2_arbiter_if;
    logic req0;
    logic req1;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic path_valid;
    logic busy;

    modport master (
        output req0, req1,
        input  sel, gnt0, gnt1, path_valid, busy
    );

    modport slave (
        input  req0, req1,
        output sel, gnt0, gnt1, path_valid, busy
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning a mux2 sel line, with settle wait after each sel change.
// Optional owner preemption after MAX_HOLD cycles: define MUX2_ARB_PREEMPT_EN.
module mux2_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 8,
    parameter int CNT_W         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mux2_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OWN    = 2'd2;
    localparam logic [CNT_W-1:0] SETTLE_INIT =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    if ((SETTLE_CYCLES >= (1 << CNT_W)) || (MAX_HOLD >= (1 << CNT_W)) || (MAX_HOLD < 1))
    begin : g_bad_cfg
        $error("mux2_arbiter: CNT_W too narrow for SETTLE_CYCLES/MAX_HOLD");
    end

    logic [1:0]       r_state;
    logic             r_sel;
    logic             r_tgt;
    logic             r_last;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_pvalid;
    logic             r_busy;
    logic [CNT_W-1:0] r_settle_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_sel_nxt;
    logic             w_tgt_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_settle_nxt;
    logic             w_pick;
    logic             w_tgt_req;
    logic             w_release;

    // Tie goes to whoever did not own last; a single requester always wins.
    assign w_pick    = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_tgt_req = r_tgt ? bus.req1 : bus.req0;

`ifdef MUX2_ARB_PREEMPT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_oth_req;

    assign w_oth_req = r_tgt ? bus.req0 : bus.req1;
    // >= so a competitor arriving after saturation still forces release.
    assign w_release = !w_tgt_req ||
                       (w_oth_req && (r_hold_cnt >= CNT_W'(MAX_HOLD - 1)));
`else
    assign w_release = !w_tgt_req;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_tgt_nxt    = r_tgt;
        w_last_nxt   = r_last;
        w_settle_nxt = r_settle_cnt;
`ifdef MUX2_ARB_PREEMPT_EN
        w_hold_nxt   = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_sel_nxt = w_pick;
                    w_tgt_nxt = w_pick;
                    if ((w_pick == r_sel) || (SETTLE_CYCLES == 0)) begin
                        w_state_nxt = ST_OWN;
                        w_last_nxt  = w_pick;
`ifdef MUX2_ARB_PREEMPT_EN
                        w_hold_nxt  = '0;
`endif
                    end else begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = SETTLE_INIT;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_tgt_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_OWN;
                    w_last_nxt  = r_tgt;
`ifdef MUX2_ARB_PREEMPT_EN
                    w_hold_nxt  = '0;
`endif
                end else begin
                    w_settle_nxt = r_settle_cnt - 1'b1;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef MUX2_ARB_PREEMPT_EN
                else if (r_hold_cnt < CNT_W'(MAX_HOLD)) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_tgt        <= 1'b0;
            r_last       <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_pvalid     <= 1'b0;
            r_busy       <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_tgt        <= w_tgt_nxt;
            r_last       <= w_last_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_gnt0       <= (w_state_nxt == ST_OWN) && !w_tgt_nxt;
            r_gnt1       <= (w_state_nxt == ST_OWN) &&  w_tgt_nxt;
            r_pvalid     <= (w_state_nxt == ST_OWN);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef MUX2_ARB_PREEMPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hold_cnt <= '0;
        else        r_hold_cnt <= w_hold_nxt;
    end
`endif

    assign bus.sel        = r_sel;
    assign bus.gnt0       = r_gnt0;
    assign bus.gnt1       = r_gnt1;
    assign bus.path_valid = r_pvalid;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus random requests
// against a cycle-level reference model. Follows MUX2_ARB_PREEMPT_EN if defined.
module tb_mux2_arbiter;
    localparam int SETTLE = 2;
    localparam int HOLD   = 8;
    localparam int CW     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    logic prev_sel = 1'b0;
    logic prev_pv  = 1'b0;

    // reference model state
    int m_own, m_settle, m_tgt, m_held;
    bit m_sel, m_last;

    mux2_arbiter_if bus_if ();

    mux2_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_HOLD(HOLD), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // invariants, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            total++;
            if (bus_if.gnt0 && bus_if.gnt1) begin
                bad++;
                $display("FAIL gnt_overlap gnt0=%b gnt1=%b want not both", bus_if.gnt0, bus_if.gnt1);
            end
            total++;
            if (prev_pv === 1'b1 && bus_if.sel !== prev_sel) begin
                bad++;
                $display("FAIL sel_stable sel=%b want %b (path_valid was 1)", bus_if.sel, prev_sel);
            end
            total++;
            if (bus_if.path_valid !== (bus_if.gnt0 | bus_if.gnt1)) begin
                bad++;
                $display("FAIL pv_eq_gnt pv=%b want %b", bus_if.path_valid, bus_if.gnt0 | bus_if.gnt1);
            end
        end
        prev_sel = bus_if.sel;
        prev_pv  = bus_if.path_valid & mon_en & rst_n;
    end

    function automatic logic [4:0] obs();
        return {bus_if.sel, bus_if.gnt0, bus_if.gnt1, bus_if.path_valid, bus_if.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_own = -1; m_settle = -1; m_tgt = 0; m_held = 0;
        m_sel = 1'b0; m_last = 1'b1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    // One clock edge of the arbiter as described in words: own / settle / arbitrate.
    task automatic model_edge(input bit r0, input bit r1);
        bit want[2];
        bit drop;
        int t;
        want[0] = r0;
        want[1] = r1;
        if (m_own >= 0) begin
            drop = !want[m_own];
`ifdef MUX2_ARB_PREEMPT_EN
            if (want[1 - m_own] && m_held >= HOLD - 1) drop = 1'b1;
`endif
            if (drop) m_own = -1;
            else if (m_held < HOLD) m_held++;
        end else if (m_settle >= 0) begin
            if (!want[m_tgt]) m_settle = -1;
            else if (m_settle == 0) begin
                m_settle = -1; m_own = m_tgt; m_last = (m_tgt == 1); m_held = 0;
            end else m_settle--;
        end else if (r0 || r1) begin
            t = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
            if (t == int'(m_sel) || SETTLE == 0) begin
                m_sel = (t == 1); m_own = t; m_last = (t == 1); m_held = 0;
            end else begin
                m_sel = (t == 1); m_tgt = t; m_settle = SETTLE - 1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 5'b0_0_0_0_0) begin
            bad++; $display("FAIL reset_state got=%b want=%b", obs(), 5'b0_0_0_0_0);
        end
    endtask

    task automatic test_fast_grant();
        do_reset();
        bus_if.req0 = 1'b1;
        tick();
        total++;
        if (obs() !== 5'b0_1_0_1_1) begin
            bad++; $display("FAIL fast_grant got=%b want=%b", obs(), 5'b0_1_0_1_1);
        end
        tick();
        total++;
        if (obs() !== 5'b0_1_0_1_1) begin
            bad++; $display("FAIL fast_hold got=%b want=%b", obs(), 5'b0_1_0_1_1);
        end
        bus_if.req0 = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b0_0_0_0_0) begin
            bad++; $display("FAIL fast_release got=%b want=%b", obs(), 5'b0_0_0_0_0);
        end
    endtask

    task automatic test_settle();
        logic [4:0] want [3] = '{5'b1_0_0_0_1, 5'b1_0_0_0_1, 5'b1_0_1_1_1};
        do_reset();
        bus_if.req1 = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            total++;
            if (obs() !== want[e]) begin
                bad++; $display("FAIL settle_edge%0d got=%b want=%b", e + 1, obs(), want[e]);
            end
        end
        bus_if.req1 = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b1_0_0_0_0) begin
            bad++; $display("FAIL settle_release got=%b want=%b", obs(), 5'b1_0_0_0_0);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] want [4] = '{5'b0_0_0_0_0, 5'b1_0_0_0_1, 5'b1_0_0_0_1, 5'b1_0_1_1_1};
        do_reset();
        bus_if.req0 = 1'b1;
        bus_if.req1 = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            total++;
            if (obs() !== 5'b0_1_0_1_1) begin
                bad++; $display("FAIL tie_owner0 cyc%0d got=%b want=%b", e, obs(), 5'b0_1_0_1_1);
            end
        end
        bus_if.req0 = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            total++;
            if (obs() !== want[e]) begin
                bad++; $display("FAIL rr_handover edge%0d got=%b want=%b", e, obs(), want[e]);
            end
        end
        bus_if.req1 = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [4:0] want [5] = '{5'b1_0_0_0_0, 5'b1_0_0_0_0, 5'b0_0_0_0_1, 5'b0_0_0_0_1, 5'b0_1_0_1_1};
        do_reset();
        bus_if.req1 = 1'b1;
        tick();
        total++;
        if (obs() !== 5'b1_0_0_0_1) begin
            bad++; $display("FAIL abort_start got=%b want=%b", obs(), 5'b1_0_0_0_1);
        end
        bus_if.req1 = 1'b0;
        for (int e = 0; e < 5; e++) begin
            if (e == 2) bus_if.req0 = 1'b1;
            tick();
            total++;
            if (obs() !== want[e]) begin
                bad++; $display("FAIL abort_seq step%0d got=%b want=%b", e, obs(), want[e]);
            end
        end
        bus_if.req0 = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        bus_if.req0 = 1'b1;
        repeat (2) tick();
        total++;
        if (obs() !== 5'b0_1_0_1_1) begin
            bad++; $display("FAIL hold_own got=%b want=%b", obs(), 5'b0_1_0_1_1);
        end
        bus_if.req1 = 1'b1;
`ifdef MUX2_ARB_PREEMPT_EN
        for (int e = 3; e <= 12; e++) begin
            logic [4:0] w;
            tick();
            w = (e <= 8) ? 5'b0_1_0_1_1 : (e == 9) ? 5'b0_0_0_0_0 :
                (e == 12) ? 5'b1_0_1_1_1 : 5'b1_0_0_0_1;
            total++;
            if (obs() !== w) begin
                bad++; $display("FAIL preempt edge%0d got=%b want=%b", e, obs(), w);
            end
        end
`else
        for (int e = 0; e < 50; e++) begin
            tick();
            total++;
            if (obs() !== 5'b0_1_0_1_1) begin
                bad++; $display("FAIL no_preempt cyc%0d got=%b want=%b", e, obs(), 5'b0_1_0_1_1);
            end
        end
`endif
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_if.req1 = 1'b1;
        repeat (3) tick();
        total++;
        if (obs() !== 5'b1_0_1_1_1) begin
            bad++; $display("FAIL areset_pre got=%b want=%b", obs(), 5'b1_0_1_1_1);
        end
        @(negedge clk);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 5'b0_0_0_0_0) begin
            bad++; $display("FAIL areset_immediate got=%b want=%b", obs(), 5'b0_0_0_0_0);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [4:0] w;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) bus_if.req0 = ~bus_if.req0;
            if ($urandom_range(3) == 0) bus_if.req1 = ~bus_if.req1;
            model_edge(bus_if.req0, bus_if.req1);
            tick();
            w = {m_sel, m_own == 0, m_own == 1, m_own >= 0, (m_own >= 0) || (m_settle >= 0)};
            total++;
            if (obs() !== w) begin
                bad++; $display("FAIL random cyc%0d got=%b want=%b", c, obs(), w);
            end
        end
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
    endtask

    initial begin
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        model_reset();
        test_reset();
        test_fast_grant();
        test_settle();
        test_round_robin();
        test_abort();
        test_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
